// File: rtl/pipeline_trace_tracker.sv
// Per-instruction trace tag producer for the 5-stage WISC pipeline.
// A sequence ID is assigned at fetch, and {valid,id,pc,instr} is carried
// through IF/ID/EX/MEM/WB with the same stall/flush behaviour as the datapath.
// Every instruction reaching WB is pushed into a small retire FIFO. A log
// consumer drains that FIFO over a valid/ready handshake.
module pipeline_trace_tracker #(
    parameter int ID_DEPTH   = 72,
    parameter int ID_W       = 7,
    parameter int PC_W       = 16,
    parameter int INSTR_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic [PC_W-1:0]    fetch_pc,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic               stall,
    input  logic               flush,
    output logic [4:0]         stage_vld,
    output logic [ID_W-1:0]    if_id,
    output logic [ID_W-1:0]    id_id,
    output logic [ID_W-1:0]    ex_id,
    output logic [ID_W-1:0]    mem_id,
    output logic [ID_W-1:0]    wb_id,
    output logic               ret_valid,
    input  logic               ret_ready,
    output logic [ID_W-1:0]    ret_id,
    output logic [PC_W-1:0]    ret_pc,
    output logic [INSTR_W-1:0] ret_instr,
    output logic [31:0]        ret_cycle,
    output logic [7:0]         drop_cnt,
    output logic               err
);

    localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(ID_DEPTH - 1);

    // Stage tags. The *_id ports are the stage ID registers themselves.
    logic               if_vld,   id_vld,   ex_vld,   mem_vld,   wb_vld;
    logic [PC_W-1:0]    if_pc,    id_pc,    ex_pc,    mem_pc,    wb_pc;
    logic [INSTR_W-1:0] if_instr, id_instr, ex_instr, mem_instr, wb_instr;

    logic [ID_W-1:0]    next_id;
    logic [ID_W-1:0]    next_id_inc;
    logic [31:0]        cycle_cnt;

    // Retire FIFO. The extra pointer bit tells full apart from empty.
    logic [ID_W-1:0]    rec_id    [FIFO_DEPTH];
    logic [PC_W-1:0]    rec_pc    [FIFO_DEPTH];
    logic [INSTR_W-1:0] rec_instr [FIFO_DEPTH];
    logic [31:0]        rec_cycle [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [PTR_W-1:0]   wr_idx;
    logic [PTR_W-1:0]   rd_idx;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push_req;
    logic               pop;
    logic               push_ok;
    logic               drop;

    // Sequence ID increment with wrap at ID_DEPTH-1.
    always_comb begin
        next_id_inc = (next_id == ID_LAST) ? '0 : next_id + ID_W'(1);
    end

    // A fetch consumes an ID only when it is actually captured into IF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_id <= '0;
        end else if (!stall && fetch_en) begin
            next_id <= next_id_inc;
        end
    end

    // IF stage: capture the fetched instruction unless it is held by a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_vld   <= 1'b0;
            if_id    <= '0;
            if_pc    <= '0;
            if_instr <= '0;
        end else if (!stall) begin
            if_vld   <= fetch_en;
            if_id    <= next_id;
            if_pc    <= fetch_pc;
            if_instr <= fetch_instr;
        end
    end

    // ID stage: take IF, squashing it on a taken branch. A stall holds ID and
    // overrides flush. A squashed ID is never reused, so retired IDs show a gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_vld   <= 1'b0;
            id_id    <= '0;
            id_pc    <= '0;
            id_instr <= '0;
        end else if (!stall) begin
            id_vld   <= if_vld & ~flush;
            id_id    <= if_id;
            id_pc    <= if_pc;
            id_instr <= if_instr;
        end
    end

    // EX stage: a stall injects a bubble. Only the valid bit matters for a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_vld   <= 1'b0;
            ex_id    <= '0;
            ex_pc    <= '0;
            ex_instr <= '0;
        end else begin
            ex_vld   <= id_vld & ~stall;
            ex_id    <= id_id;
            ex_pc    <= id_pc;
            ex_instr <= id_instr;
        end
    end

    // MEM stage: always advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_vld   <= 1'b0;
            mem_id    <= '0;
            mem_pc    <= '0;
            mem_instr <= '0;
        end else begin
            mem_vld   <= ex_vld;
            mem_id    <= ex_id;
            mem_pc    <= ex_pc;
            mem_instr <= ex_instr;
        end
    end

    // WB stage: always advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vld   <= 1'b0;
            wb_id    <= '0;
            wb_pc    <= '0;
            wb_instr <= '0;
        end else begin
            wb_vld   <= mem_vld;
            wb_id    <= mem_id;
            wb_pc    <= mem_pc;
            wb_instr <= mem_instr;
        end
    end

    // Free-running cycle stamp. It wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Sticky hazard-conflict flag: flush and stall must never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (stall && flush) begin
            err <= 1'b1;
        end
    end

    // FIFO status and handshake decode. A full FIFO still accepts a push when
    // the head leaves in the same cycle.
    always_comb begin
        wr_idx     = wr_ptr[PTR_W-1:0];
        rd_idx     = rd_ptr[PTR_W-1:0];
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_idx == rd_idx) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
        push_req   = wb_vld;
        pop        = !fifo_empty && ret_ready;
        push_ok    = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
    end

    // FIFO pointers. Resetting them discards every queued record at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Record storage. When the FIFO is full and a pop happens in the same
    // cycle, the write slot is the head being popped, which is safe because
    // the head has already been read out combinationally.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            rec_id[wr_idx]    <= wb_id;
            rec_pc[wr_idx]    <= wb_pc;
            rec_instr[wr_idx] <= wb_instr;
            rec_cycle[wr_idx] <= cycle_cnt;
        end
    end

    // Lost-record counter, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Output view: stage valids and the FIFO head, straight from storage.
    always_comb begin
        stage_vld = {wb_vld, mem_vld, ex_vld, id_vld, if_vld};
        ret_valid = !fifo_empty;
        ret_id    = rec_id[rd_idx];
        ret_pc    = rec_pc[rd_idx];
        ret_instr = rec_instr[rd_idx];
        ret_cycle = rec_cycle[rd_idx];
    end

endmodule

// File: tb/tb_pipeline_trace_tracker.sv
// Bench for pipeline_trace_tracker. Expected retire records are queued when
// each fetch is driven and are compared when the consumer pops them.
module tb_pipeline_trace_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [15:0] fetch_pc;
    logic [15:0] fetch_instr;
    logic        stall;
    logic        flush;
    logic [4:0]  stage_vld;
    logic [6:0]  if_id, id_id, ex_id, mem_id, wb_id;
    logic        ret_valid;
    logic        ret_ready;
    logic [6:0]  ret_id;
    logic [15:0] ret_pc;
    logic [15:0] ret_instr;
    logic [31:0] ret_cycle;
    logic [7:0]  drop_cnt;
    logic        err;

    pipeline_trace_tracker dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr), .stall(stall), .flush(flush),
        .stage_vld(stage_vld), .if_id(if_id), .id_id(id_id), .ex_id(ex_id),
        .mem_id(mem_id), .wb_id(wb_id), .ret_valid(ret_valid),
        .ret_ready(ret_ready), .ret_id(ret_id), .ret_pc(ret_pc),
        .ret_instr(ret_instr), .ret_cycle(ret_cycle), .drop_cnt(drop_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  id;
        logic [15:0] pc;
        logic [15:0] instr;
        bit          chk_cyc;
        logic [31:0] cyc;
    } rec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [31:0] exp_cyc;
    } vec_t;

    rec_t        exp_q[$];
    rec_t        mon_e;
    vec_t        t1_vec[8];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tb_next_id = 0;
    logic [15:0] tb_pc = '0;
    bit          if_has = 1'b0;
    bit          seen_wrap = 1'b0;
    int          prev_id = -1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int id_sub(input int a, input int k);
        return (a + 72 - k) % 72;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of fetch inputs and update the expected-retire model.
    task automatic drive(input bit en, input bit st, input bit fl, input bit keep,
                         input logic [15:0] pc, input logic [15:0] ins,
                         input bit chk, input logic [31:0] cyc);
        rec_t r;
        fetch_en    = en;
        fetch_pc    = pc;
        fetch_instr = ins;
        stall       = st;
        flush       = fl;
        if (!st) begin
            if (fl && if_has) r = exp_q.pop_back();
            if (en) begin
                if (keep) begin
                    r.id      = 7'(tb_next_id);
                    r.pc      = pc;
                    r.instr   = ins;
                    r.chk_cyc = chk;
                    r.cyc     = cyc;
                    exp_q.push_back(r);
                end
                tb_next_id = (tb_next_id + 1) % 72;
                tb_pc      = pc + 16'd2;
            end
            if_has = en;
        end
    endtask

    task automatic run(input bit en, input bit st, input bit fl, input bit keep);
        drive(en, st, fl, keep, tb_pc, tb_pc ^ 16'hC3A5, 1'b0, 32'd0);
        step();
    endtask

    // Consumer-side scoreboard: compare every record that is popped.
    always @(negedge clk) begin
        if (!rst && ret_valid && ret_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ret_unexpected: got id %0d expected no record", ret_id);
            end else begin
                mon_e = exp_q.pop_front();
                cmp("ret_id", 32'(ret_id), 32'(mon_e.id));
                cmp("ret_pc", 32'(ret_pc), 32'(mon_e.pc));
                cmp("ret_instr", 32'(ret_instr), 32'(mon_e.instr));
                if (mon_e.chk_cyc) cmp("ret_cycle", ret_cycle, mon_e.cyc);
            end
            if (prev_id == 71 && ret_id == 7'd0) seen_wrap = 1'b1;
            prev_id = int'(ret_id);
        end
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected $finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            t1_vec[i].pc      = 16'(2 * i);
            t1_vec[i].instr   = 16'hA000 | 16'(i);
            t1_vec[i].exp_cyc = 32'(5 + i);
        end

        rst = 1'b1;
        fetch_en = 1'b0; fetch_pc = '0; fetch_instr = '0;
        stall = 1'b0; flush = 1'b0; ret_ready = 1'b1;
        repeat (2) step();

        // Reset state
        cmp("rst_stage_vld", 32'(stage_vld), 32'd0);
        cmp("rst_if_id", 32'(if_id), 32'd0);
        cmp("rst_wb_id", 32'(wb_id), 32'd0);
        cmp("rst_ret_valid", 32'(ret_valid), 32'd0);
        cmp("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        cmp("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // T1: table-driven stream, first record after the 6th edge
        for (int i = 0; i < 8; i++) begin
            if (i == 5) cmp("t1_ret_valid_e5", 32'(ret_valid), 32'd0);
            if (i == 6) cmp("t1_ret_valid_e6", 32'(ret_valid), 32'd1);
            drive(1'b1, 1'b0, 1'b0, 1'b1, t1_vec[i].pc, t1_vec[i].instr, 1'b1, t1_vec[i].exp_cyc);
            step();
        end

        // T2: two-cycle stall holds IF/ID and bubbles EX
        run(1, 0, 0, 1);
        run(1, 0, 0, 1);
        run(1, 1, 0, 1);
        cmp("t2_ex_bubble", 32'(stage_vld[2]), 32'd0);
        cmp("t2_ifid_valid", 32'(stage_vld[1:0]), 32'd3);
        cmp("t2_id_hold", 32'(id_id), 32'(id_sub(tb_next_id, 2)));
        cmp("t2_if_hold", 32'(if_id), 32'(id_sub(tb_next_id, 1)));
        run(1, 1, 0, 1);
        cmp("t2_mem_bubble", 32'(stage_vld[3:2]), 32'd0);
        cmp("t2_id_hold2", 32'(id_id), 32'(id_sub(tb_next_id, 2)));
        cmp("t2_err_clear", 32'(err), 32'd0);
        repeat (3) run(1, 0, 0, 1);

        // T3: flush squashes the instruction in IF
        run(1, 0, 1, 1);
        cmp("t3_id_squashed", 32'(stage_vld[1]), 32'd0);
        repeat (2) run(1, 0, 0, 1);
        repeat (12) run(0, 0, 0, 1);
        cmp("t3_drop_cnt", 32'(drop_cnt), 32'd0);
        cmp("t3_drained", 32'(ret_valid), 32'd0);
        cmp("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // T4: stalled consumer; 5th and 6th records dropped, 7th pushed with a pop
        ret_ready = 1'b0;
        for (int i = 0; i < 8; i++) run(1, 0, 0, (i != 4) && (i != 5));
        repeat (3) run(0, 0, 0, 1);
        cmp("t4_ret_valid", 32'(ret_valid), 32'd1);
        cmp("t4_head_stable", 32'(ret_id), 32'(exp_q[0].id));
        cmp("t4_drop_cnt", 32'(drop_cnt), 32'd2);
        cmp("t4_wb_valid", 32'(stage_vld[4]), 32'd1);
        ret_ready = 1'b1;
        repeat (12) run(0, 0, 0, 1);
        cmp("t4_drop_after", 32'(drop_cnt), 32'd2);
        cmp("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // T5: long stream crossing the ID wrap
        repeat (80) run(1, 0, 0, 1);
        repeat (12) run(0, 0, 0, 1);
        cmp("t5_wrap_seen", 32'(seen_wrap), 32'd1);

        // T6: stall+flush together, then async reset mid-stream
        repeat (3) run(1, 0, 0, 1);
        run(1, 1, 1, 1);
        cmp("t6_err_set", 32'(err), 32'd1);
        cmp("t6_no_squash", 32'(stage_vld[1:0]), 32'd3);
        cmp("t6_if_hold", 32'(if_id), 32'(id_sub(tb_next_id, 1)));
        cmp("t6_id_hold", 32'(id_id), 32'(id_sub(tb_next_id, 2)));
        repeat (2) run(1, 0, 0, 1);
        cmp("t6_err_sticky", 32'(err), 32'd1);
        cmp("t6_pre_rst_busy", 32'(stage_vld != 5'd0), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        cmp("t6_async_stage_vld", 32'(stage_vld), 32'd0);
        cmp("t6_async_ret_valid", 32'(ret_valid), 32'd0);
        cmp("t6_async_err", 32'(err), 32'd0);
        exp_q.delete();
        tb_next_id = 0; tb_pc = '0; if_has = 1'b0; prev_id = -1;
        fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) run(1, 0, 0, 1);
        repeat (12) run(0, 0, 0, 1);
        cmp("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
